// File: rtl/imem_loader_if.sv
// Stream-in / instruction-memory-write bundle for imem_loader.
// The loader binds to the slave modport; the side feeding bytes binds to master.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, error, word_count
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, error, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed big-endian byte stream packed into
// 32-bit words written to consecutive addresses from 0, with the CPU held meanwhile.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_word;
  logic [1:0]        r_idx;
  logic [ADDR_W:0]   r_word_count;
  logic              r_error;

  logic              w_byte_ready;
  logic              w_accept;
  logic              w_idle_start;
  logic              w_len_bad;
  logic              w_last_word;
  logic [15:0]       w_len;
  logic [ADDR_W:0]   w_count_inc;

  // Length bytes shift in MSB first, so LEN_LO completes the count combinationally.
  assign w_len        = {r_len[7:0], bus.byte_in};
  assign w_accept     = bus.byte_valid && w_byte_ready;
  assign w_idle_start = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_len_bad    = 32'(w_len) > DEPTH_U;
  assign w_count_inc  = r_word_count + (ADDR_W + 1)'(1);
  assign w_last_word  = 32'(w_count_inc) == 32'(r_len);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: defaults first, so no path through the case leaves a signal
  // unassigned and infers a latch.
  always_comb begin
    w_next       = r_state;
    w_byte_ready = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid) w_next = (w_len == 16'd0 || w_len_bad) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid && r_idx == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last_word ? S_DONE : S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len        <= '0;
      r_addr       <= '0;
      r_word       <= '0;
      r_idx        <= '0;
      r_word_count <= '0;
      r_error      <= 1'b0;
    end else begin
      if (w_idle_start) begin
        r_len        <= '0;
        r_addr       <= '0;
        r_idx        <= '0;
        r_word_count <= '0;
        r_error      <= 1'b0;
      end
      if ((r_state == S_LEN_HI || r_state == S_LEN_LO) && w_accept) r_len <= w_len;
      if (r_state == S_LEN_LO && w_accept && w_len_bad) r_error <= 1'b1;
      // r_idx wraps 3 -> 0 on its own, ready for the next word.
      if (r_state == S_DATA && w_accept) begin
        r_word <= {r_word[23:0], bus.byte_in};
        r_idx  <= r_idx + 2'd1;
      end
      if (r_state == S_WRITE) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_word_count <= w_count_inc;
      end
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.wr_en      = (r_state == S_WRITE);
  assign bus.wr_addr    = r_addr;
  assign bus.wr_data    = r_word;
  assign bus.busy       = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                          (r_state == S_DATA)   || (r_state == S_WRITE);
  assign bus.cpu_hold   = bus.busy;
  assign bus.done       = (r_state == S_DONE);
  assign bus.error      = r_error;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: loads are modelled as lists of
// expected (address, word) writes; a negedge monitor pops and compares them.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_wr_t     exp_q[$];
  logic [31:0] tx_words[$];
  int          vectors     = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    exp_wr_t e;
    if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                 bus.wr_addr, bus.wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        check("wr_data", 64'(bus.wr_data), 64'(e.data));
        check("ready_in_write", 64'(bus.byte_ready), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},      64'(bus.wr_en),      64'd0);
    check({tag, "_wr_addr"},    64'(bus.wr_addr),    64'd0);
    check({tag, "_wr_data"},    64'(bus.wr_data),    64'd0);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_cpu_hold"},   64'(bus.cpu_hold),   64'd0);
    check({tag, "_done"},       64'(bus.done),       64'd0);
    check({tag, "_error"},      64'(bus.error),      64'd0);
    check({tag, "_word_count"}, 64'(bus.word_count), 64'd0);
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
  endtask

  function automatic int pick_gap(input int gap);
    return (gap < 0) ? int'($urandom_range(0, 2)) : gap;
  endfunction

  // Entered and left at a negedge; the posedge in between does the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.byte_ready !== 1'b1) check("accept_timeout", 64'(bus.byte_ready), 64'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One complete load of tx_words with declared length n; start_at >= 0
  // injects an (ignored) start pulse before that word.
  task automatic do_load(input int n, input int gap, input int start_at);
    logic [15:0] len;
    logic [31:0] w;
    exp_wr_t     e;
    int          t;
    int          exp_count;
    len       = 16'(n);
    exp_count = (n <= DEPTH) ? n : 0;
    for (int i = 0; i < exp_count; i++) begin
      e.addr = ADDR_W'(i);
      e.data = tx_words[i];
      exp_q.push_back(e);
    end
    pulse_start();
    send_byte(len[15:8], pick_gap(gap));
    send_byte(len[7:0],  pick_gap(gap));
    if (exp_count == 0) begin
      check("done_after_len", 64'(bus.done),  64'd1);
      check("error_after_len", 64'(bus.error), 64'(n > DEPTH));
    end
    for (int i = 0; i < exp_count; i++) begin
      if (i == start_at) begin
        pulse_start();
        check("busy_after_ignored_start", 64'(bus.busy), 64'd1);
      end
      w = tx_words[i];
      for (int b = 0; b < 4; b++) send_byte(w[31 - 8*b -: 8], pick_gap(gap));
    end
    t = 0;
    while (bus.done !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("done",        64'(bus.done),       64'd1);
    check("error",       64'(bus.error),      64'(n > DEPTH));
    check("word_count",  64'(bus.word_count), 64'(exp_count));
    check("busy_end",    64'(bus.busy),       64'd0);
    check("cpu_hold_end", 64'(bus.cpu_hold),  64'd0);
    check("ready_end",   64'(bus.byte_ready), 64'd0);
    check("writes_left", 64'(exp_q.size()),   64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(bus.byte_ready), 64'd0);
    check("idle_busy",  64'(bus.busy),       64'd0);

    // Basic two-word load, then N=0, then oversize length.
    tx_words = '{32'h20080005, 32'hAC010004};
    do_load(2, 0, -1);
    tx_words.delete();
    do_load(0, 0, -1);
    do_load(257, 0, -1);

    // Bytes offered in DONE must not be consumed.
    bus.byte_in    = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_ready_held", 64'(bus.byte_ready), 64'd0);
    check("done_held",       64'(bus.done),       64'd1);
    check("error_held",      64'(bus.error),      64'd1);
    bus.byte_valid = 1'b0;

    // Same two words with 3-cycle valid gaps.
    tx_words = '{32'h20080005, 32'hAC010004};
    do_load(2, 3, -1);

    // Reset after two data bytes discards the partial word.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_load(2, 0, -1);

    // Randomized loads, including one oversize length.
    repeat (6) begin
      int n = int'($urandom_range(1, 12));
      tx_words.delete();
      for (int i = 0; i < n; i++) tx_words.push_back($urandom);
      do_load(n, -1, -1);
    end
    tx_words.delete();
    do_load(int'($urandom_range(DEPTH + 1, 65535)), -1, -1);

    // Full-depth load with word == address and a start pulse mid-load.
    tx_words.delete();
    for (int i = 0; i < DEPTH; i++) tx_words.push_back(32'(i));
    do_load(DEPTH, 0, 100);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
